// File: rtl/dvi_tmds_pkg.sv
// Shared TMDS constants and helpers for the DVI encoder: control symbols,
// reset symbol, running-disparity width and an 8-bit popcount.
package dvi_tmds_pkg;

  localparam int CNT_W = 5;

  localparam logic [9:0] CTRL_00 = 10'b1101010100;
  localparam logic [9:0] CTRL_01 = 10'b0010101011;
  localparam logic [9:0] CTRL_10 = 10'b0101010100;
  localparam logic [9:0] CTRL_11 = 10'b1010101011;

  localparam logic [9:0] TMDS_RST_SYM = CTRL_00;

  function automatic logic [3:0] popcount8(input logic [7:0] v);
    logic [3:0] n;
    n = '0;
    for (int i = 0; i < 8; i++) n = n + {3'b000, v[i]};
    return n;
  endfunction

  function automatic logic [9:0] ctrl_code(input logic [1:0] c);
    logic [9:0] sym;
    case (c)
      2'b00:   sym = CTRL_00;
      2'b01:   sym = CTRL_01;
      2'b10:   sym = CTRL_10;
      default: sym = CTRL_11;
    endcase
    return sym;
  endfunction

endpackage

// File: rtl/tmds_channel_enc.sv
// One TMDS channel: transition-minimising stage, then DC-balancing stage with
// its own running disparity. Two-cycle latency, one symbol per clock.
module tmds_channel_enc
  import dvi_tmds_pkg::*;
(
  input  logic       clk,
  input  logic       rst_n,
  input  logic       de,
  input  logic       c1,
  input  logic       c0,
  input  logic [7:0] data,
  output logic [9:0] tmds
);

  logic [3:0]              n1_p0;
  logic                    xnor_mode_p0;
  logic [8:0]              qm_p1_d, qm_p1_q;
  logic                    de_p1_q;
  logic [1:0]              ctrl_p1_q;

  logic [3:0]              n1q_p1;
  logic signed [5:0]       bal_p1, two_q8_p1, cnt_ext_p1, delta_p1, sum_p1;
  logic signed [CNT_W-1:0] cnt_d, cnt_q;
  logic [9:0]              sym_p2_d, sym_p2_q;

  always_comb begin
    n1_p0        = popcount8(data);
    xnor_mode_p0 = (n1_p0 > 4'd4) || ((n1_p0 == 4'd4) && !data[0]);
    qm_p1_d      = '0;
    qm_p1_d[0]   = data[0];
    for (int i = 1; i < 8; i++)
      qm_p1_d[i] = xnor_mode_p0 ? ~(qm_p1_d[i-1] ^ data[i]) : (qm_p1_d[i-1] ^ data[i]);
    qm_p1_d[8]   = ~xnor_mode_p0;
  end

  // ---- stage 1 register: q_m with DE and control delayed alongside ----
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      qm_p1_q   <= '0;
      de_p1_q   <= 1'b0;
      ctrl_p1_q <= 2'b00;
    end else begin
      qm_p1_q   <= qm_p1_d;
      de_p1_q   <= de;
      ctrl_p1_q <= {c1, c0};
    end
  end

  // bal is n1q - n0q, expressed as 2*n1q - 8 so a single popcount suffices.
  always_comb begin
    n1q_p1     = popcount8(qm_p1_q[7:0]);
    bal_p1     = $signed({1'b0, n1q_p1, 1'b0}) - 6'sd8;
    two_q8_p1  = $signed({4'b0000, qm_p1_q[8], 1'b0});
    cnt_ext_p1 = {cnt_q[CNT_W-1], cnt_q};
    delta_p1   = '0;
    sum_p1     = '0;
    cnt_d      = '0;
    sym_p2_d   = TMDS_RST_SYM;
    if (!de_p1_q) begin
      sym_p2_d = ctrl_code(ctrl_p1_q);
    end else begin
      if ((cnt_q == '0) || (n1q_p1 == 4'd4)) begin
        sym_p2_d = {~qm_p1_q[8], qm_p1_q[8], qm_p1_q[8] ? qm_p1_q[7:0] : ~qm_p1_q[7:0]};
        delta_p1 = qm_p1_q[8] ? bal_p1 : -bal_p1;
      end else if ((!cnt_q[CNT_W-1] && (n1q_p1 > 4'd4)) ||
                   (cnt_q[CNT_W-1] && (n1q_p1 < 4'd4))) begin
        sym_p2_d = {1'b1, qm_p1_q[8], ~qm_p1_q[7:0]};
        delta_p1 = two_q8_p1 - bal_p1;
      end else begin
        sym_p2_d = {1'b0, qm_p1_q[8], qm_p1_q[7:0]};
        delta_p1 = bal_p1 - 6'sd2 + two_q8_p1;
      end
      sum_p1 = cnt_ext_p1 + delta_p1;
      cnt_d  = sum_p1[CNT_W-1:0];
    end
  end

  // ---- stage 2 register: output symbol and running disparity ----
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sym_p2_q <= TMDS_RST_SYM;
      cnt_q    <= '0;
    end else begin
      sym_p2_q <= sym_p2_d;
      cnt_q    <= cnt_d;
    end
  end

  assign tmds = sym_p2_q;

endmodule

// File: rtl/dvi_tmds_encoder.sv
// Three-channel DVI TMDS encoder. Define TMDS_OUT_REG_EN to add one output
// register stage (latency 3 instead of 2) for timing toward the serialiser.
module dvi_tmds_encoder
  import dvi_tmds_pkg::*;
(
  input  logic       I_pxl_clk,
  input  logic       I_rst_n,
  input  logic       I_de,
  input  logic       I_hs,
  input  logic       I_vs,
  input  logic [7:0] I_data_r,
  input  logic [7:0] I_data_g,
  input  logic [7:0] I_data_b,
  output logic [9:0] O_tmds_r,
  output logic [9:0] O_tmds_g,
  output logic [9:0] O_tmds_b
);

  logic [9:0] sym_r, sym_g, sym_b;

  // Only the blue channel carries sync during blanking.
  tmds_channel_enc u_enc_b (
    .clk(I_pxl_clk), .rst_n(I_rst_n), .de(I_de), .c1(I_vs), .c0(I_hs),
    .data(I_data_b), .tmds(sym_b)
  );

  tmds_channel_enc u_enc_g (
    .clk(I_pxl_clk), .rst_n(I_rst_n), .de(I_de), .c1(1'b0), .c0(1'b0),
    .data(I_data_g), .tmds(sym_g)
  );

  tmds_channel_enc u_enc_r (
    .clk(I_pxl_clk), .rst_n(I_rst_n), .de(I_de), .c1(1'b0), .c0(1'b0),
    .data(I_data_r), .tmds(sym_r)
  );

`ifdef TMDS_OUT_REG_EN
  logic [9:0] tmds_r_q, tmds_g_q, tmds_b_q;

  // ---- output register stage ----
  always_ff @(posedge I_pxl_clk or negedge I_rst_n) begin
    if (!I_rst_n) begin
      tmds_r_q <= TMDS_RST_SYM;
      tmds_g_q <= TMDS_RST_SYM;
      tmds_b_q <= TMDS_RST_SYM;
    end else begin
      tmds_r_q <= sym_r;
      tmds_g_q <= sym_g;
      tmds_b_q <= sym_b;
    end
  end

  assign O_tmds_r = tmds_r_q;
  assign O_tmds_g = tmds_g_q;
  assign O_tmds_b = tmds_b_q;
`else
  assign O_tmds_r = sym_r;
  assign O_tmds_g = sym_g;
  assign O_tmds_b = sym_b;
`endif

endmodule

// File: tb/tb_dvi_tmds_encoder.sv
// Randomised bench for dvi_tmds_encoder against a disparity-tracking TMDS
// reference model; honours TMDS_OUT_REG_EN for the extra latency cycle.
module tb_dvi_tmds_encoder;

`ifdef TMDS_OUT_REG_EN
  localparam int LAT = 3;
`else
  localparam int LAT = 2;
`endif

  localparam logic [9:0] RST_SYM = 10'b1101010100;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       de, hs, vs;
  logic [7:0] dr, dg, db;
  logic [9:0] tmds_r_o, tmds_g_o, tmds_b_o;

  always #5 clk = ~clk;

  dvi_tmds_encoder dut (
    .I_pxl_clk(clk), .I_rst_n(rst_n), .I_de(de), .I_hs(hs), .I_vs(vs),
    .I_data_r(dr), .I_data_g(dg), .I_data_b(db),
    .O_tmds_r(tmds_r_o), .O_tmds_g(tmds_g_o), .O_tmds_b(tmds_b_o)
  );

  int n_checks = 0;
  int n_fail   = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  // Reference model: per-channel disparity plus a delay line of expected outputs.
  int         mcnt [3];
  logic [9:0] psym [LAT][3];
  logic       pde  [LAT];
  logic [7:0] ppx  [LAT][3];

  function automatic logic [9:0] ref_enc(input int ch, input logic de_i,
                                         input logic [1:0] c, input logic [7:0] d);
    int         n1, n1q, diff;
    logic       xn, q8;
    logic [7:0] qlo, m;
    logic [9:0] sym;
    if (!de_i) begin
      mcnt[ch] = 0;
      case (c)
        2'b00:   sym = 10'b1101010100;
        2'b01:   sym = 10'b0010101011;
        2'b10:   sym = 10'b0101010100;
        default: sym = 10'b1010101011;
      endcase
    end else begin
      n1 = $countones(d);
      xn = (n1 > 4) || (n1 == 4 && d[0] == 1'b0);
      // q_m[i] is the prefix parity of D, inverted on odd bits in XNOR mode
      for (int i = 0; i < 8; i++) begin
        m      = 8'((1 << (i + 1)) - 1);
        qlo[i] = (^(d & m)) ^ (xn && (i % 2 == 1));
      end
      q8   = !xn;
      n1q  = $countones(qlo);
      diff = n1q - (8 - n1q);
      if (mcnt[ch] == 0 || diff == 0) begin
        sym = {~q8, q8, q8 ? qlo : ~qlo};
        mcnt[ch] += q8 ? diff : -diff;
      end else if ((mcnt[ch] > 0 && diff > 0) || (mcnt[ch] < 0 && diff < 0)) begin
        sym = {1'b1, q8, ~qlo};
        mcnt[ch] += (q8 ? 2 : 0) - diff;
      end else begin
        sym = {1'b0, q8, qlo};
        mcnt[ch] += diff - (q8 ? 0 : 2);
      end
    end
    return sym;
  endfunction

  function automatic logic [7:0] decode(input logic [9:0] s);
    logic [7:0] d, o;
    d    = s[9] ? ~s[7:0] : s[7:0];
    o[0] = d[0];
    for (int i = 1; i < 8; i++) o[i] = s[8] ? (d[i] ^ d[i-1]) : ~(d[i] ^ d[i-1]);
    return o;
  endfunction

  task automatic model_reset();
    for (int k = 0; k < LAT; k++) begin
      pde[k] = 1'b0;
      for (int c = 0; c < 3; c++) begin
        psym[k][c] = RST_SYM;
        ppx[k][c]  = 8'h00;
      end
    end
    for (int c = 0; c < 3; c++) mcnt[c] = 0;
  endtask

  task automatic tick();
    logic [9:0] got [3];
    @(posedge clk);
    if (!rst_n) begin
      model_reset();
    end else begin
      for (int k = LAT - 1; k > 0; k--) begin
        pde[k] = pde[k-1];
        for (int c = 0; c < 3; c++) begin
          psym[k][c] = psym[k-1][c];
          ppx[k][c]  = ppx[k-1][c];
        end
      end
      pde[0]     = de;
      ppx[0][0]  = dr;
      ppx[0][1]  = dg;
      ppx[0][2]  = db;
      psym[0][0] = ref_enc(0, de, 2'b00, dr);
      psym[0][1] = ref_enc(1, de, 2'b00, dg);
      psym[0][2] = ref_enc(2, de, {vs, hs}, db);
    end
    #1;
    got[0] = tmds_r_o;
    got[1] = tmds_g_o;
    got[2] = tmds_b_o;
    chk("sym_r", got[0], psym[LAT-1][0]);
    chk("sym_g", got[1], psym[LAT-1][1]);
    chk("sym_b", got[2], psym[LAT-1][2]);
    if (pde[LAT-1]) begin
      chk("dec_r", decode(got[0]), ppx[LAT-1][0]);
      chk("dec_g", decode(got[1]), ppx[LAT-1][1]);
      chk("dec_b", decode(got[2]), ppx[LAT-1][2]);
    end
  endtask

  task automatic drive(input logic de_i, input logic hs_i, input logic vs_i,
                       input logic [7:0] r, input logic [7:0] g, input logic [7:0] b);
    de = de_i; hs = hs_i; vs = vs_i; dr = r; dg = g; db = b;
  endtask

  task automatic chk_cnt_bounds();
    int c;
    c = dut.u_enc_r.cnt_q; chk("cnt_r_bound", (c >= -10 && c <= 10), 1);
    c = dut.u_enc_g.cnt_q; chk("cnt_g_bound", (c >= -10 && c <= 10), 1);
    c = dut.u_enc_b.cnt_q; chk("cnt_b_bound", (c >= -10 && c <= 10), 1);
  endtask

  initial begin
    int cval;
    rst_n = 1'b0;
    drive(1'b0, 1'b1, 1'b0, 8'h00, 8'h00, 8'h00);
    model_reset();
    #12;
    chk("rst_r", tmds_r_o, RST_SYM);
    chk("rst_g", tmds_g_o, RST_SYM);
    chk("rst_b", tmds_b_o, RST_SYM);
    rst_n = 1'b1;

    // Idle blanking with HS=1: blue carries control code 01.
    repeat (LAT) tick();
    chk("idle_hs_b", tmds_b_o, 10'b0010101011);
    chk("idle_hs_r", tmds_r_o, RST_SYM);
    chk("idle_hs_g", tmds_g_o, RST_SYM);

    // Sync change must land exactly LAT clocks after the input edge.
    drive(1'b0, 1'b0, 1'b1, 8'h00, 8'h00, 8'h00);
    repeat (LAT - 1) tick();
    chk("vs_early_b", tmds_b_o, 10'b0010101011);
    tick();
    chk("vs_b", tmds_b_o, 10'b0101010100);

    // All-zero pixels from cnt=0, then the balancing symbol.
    drive(1'b1, 1'b0, 1'b0, 8'h00, 8'h00, 8'h00);
    repeat (LAT) tick();
    chk("zero1_r", tmds_r_o, 10'b0100000000);
    chk("zero1_b", tmds_b_o, 10'b0100000000);
    tick();
    chk("zero2_r", tmds_r_o, 10'b1111111111);
    chk("zero2_g", tmds_g_o, 10'b1111111111);
    cval = dut.u_enc_r.cnt_q;
    chk("zero2_cnt", cval, 2);

    // All-ones pixels after blanking clears the disparity.
    drive(1'b0, 1'b0, 1'b0, 8'h00, 8'h00, 8'h00);
    tick();
    drive(1'b1, 1'b0, 1'b0, 8'hFF, 8'hFF, 8'hFF);
    repeat (LAT) tick();
    chk("ff_r", tmds_r_o, 10'b1000000000);
    chk("ff_b", tmds_b_o, 10'b1000000000);

    // Long active burst with random pixels.
    for (int i = 0; i < 4096; i++) begin
      drive(1'b1, 1'($urandom), 1'($urandom), 8'($urandom), 8'($urandom), 8'($urandom));
      tick();
      chk_cnt_bounds();
    end

    // Mixed blanking/active traffic with random sync.
    for (int i = 0; i < 400; i++) begin
      drive(($urandom_range(0, 7) != 0), 1'($urandom), 1'($urandom),
            8'($urandom), 8'($urandom), 8'($urandom));
      tick();
    end

    // Mid-line asynchronous reset with nonzero disparity.
    drive(1'b0, 1'b0, 1'b0, 8'h00, 8'h00, 8'h00);
    tick();
    drive(1'b1, 1'b0, 1'b0, 8'h00, 8'h00, 8'h00);
    repeat (LAT) tick();
    cval = dut.u_enc_b.cnt_q;
    chk("cnt_pre_rst", (cval != 0), 1);
    #2;
    rst_n = 1'b0;
    #1;
    chk("midrst_r", tmds_r_o, RST_SYM);
    chk("midrst_g", tmds_g_o, RST_SYM);
    chk("midrst_b", tmds_b_o, RST_SYM);
    model_reset();
    repeat (2) tick();
    #3;
    rst_n = 1'b1;
    repeat (LAT) tick();
    chk("post_rst_r", tmds_r_o, 10'b0100000000);
    chk("post_rst_b", tmds_b_o, 10'b0100000000);
    repeat (4) tick();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
